// File: rtl/keypad_conditioner.sv
// Synchronizes, debounces and edge-detects 8 mole buttons into a one-hot press handshake.
// Latency: a stable raw change shows up on held after DEBOUNCE_CYCLES+2 edges, key_valid one edge later.
// Backpressure: a single-entry buffer held until ack; a press arriving while full and un-acked is dropped with an overrun pulse.
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] keypad,
  input  logic       ack,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic [2:0] key_index,
  output logic [7:0] held,
  output logic       overrun,
  output logic       reject,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  logic [7:0]       s1, s2, prev;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       held_d;
  logic [7:0]       rise;
  logic             press_evt;
  logic             multi_key;
  state_t           state;

  // Number of set bits, used to tell a clean single-key press from a chord.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Binary index of the (single) set bit; only meaningful for one-hot inputs.
  function automatic logic [2:0] encode8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Two-flop synchronizer plus one extra stage so the debouncer can see sample-to-sample change.
  always_ff @(posedge clk) begin
    if (RESET) begin
      s1   <= 8'h00;
      s2   <= 8'h00;
      prev <= 8'h00;
    end else begin
      s1   <= keypad;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Vector-wide debounce: any movement on any key restarts the count; accept after a full stable run.
  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt    <= '0;
      held   <= 8'h00;
      held_d <= 8'h00;
    end else begin
      held_d <= held;
      if ((s2 != prev) || (s2 == held)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        held <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Only newly pressed keys count as events; releases are ignored.
  assign rise      = held & ~held_d;
  assign press_evt = |rise;
  assign multi_key = (popcount8(held) >= 4'd2);
  assign key_valid = (state == FULL);

  // One-entry output buffer; code/index are cleared whenever the buffer empties so they read 0 when idle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= EMPTY;
      key_code  <= 8'h00;
      key_index <= 3'd0;
      overrun   <= 1'b0;
      reject    <= 1'b0;
      press_cnt <= 8'h00;
    end else begin
      overrun <= 1'b0;
      reject  <= 1'b0;
      if (press_evt && multi_key) begin
        // Chords are never loaded, but an ack in the same cycle still consumes the pending entry.
        reject <= 1'b1;
        if ((state == FULL) && ack) begin
          state     <= EMPTY;
          key_code  <= 8'h00;
          key_index <= 3'd0;
        end
      end else if (press_evt) begin
        if ((state == EMPTY) || ack) begin
          state     <= FULL;
          key_code  <= held;
          key_index <= encode8(held);
          press_cnt <= press_cnt + 8'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if ((state == FULL) && ack) begin
        state     <= EMPTY;
        key_code  <= 8'h00;
        key_index <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner with DEBOUNCE_CYCLES = 4.
// Stimulus pushes expected loads/overruns/rejects with their expected cycle; a monitor pops on each DUT event.
// Direct checks cover reset state and buffer contents around ack.
module tb_keypad_conditioner;

  localparam int D = 4;
  localparam int K_LOAD = 0;
  localparam int K_OVR  = 1;
  localparam int K_REJ  = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic [2:0] idx;
    logic [7:0] cnt;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] keypad;
  logic       ack;
  logic       key_valid;
  logic [7:0] key_code;
  logic [2:0] key_index;
  logic [7:0] held;
  logic       overrun;
  logic       reject;
  logic [7:0] press_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   model_cnt = 0;
  exp_t expq[$];

  keypad_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .keypad    (keypad),
    .ack       (ack),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_index (key_index),
    .held      (held),
    .overrun   (overrun),
    .reject    (reject),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected load: the raw change set now is sampled next edge and appears D+3 edges after that.
  task automatic push_load(input logic [7:0] code, input logic [2:0] idx);
    exp_t e;
    model_cnt = (model_cnt + 1) % 256;
    e.kind = K_LOAD; e.code = code; e.idx = idx; e.cnt = 8'(model_cnt); e.at = cyc + D + 4;
    expq.push_back(e);
  endtask

  task automatic push_pulse(input int kind);
    exp_t e;
    e.kind = kind; e.code = 8'h00; e.idx = 3'd0; e.cnt = 8'h00; e.at = cyc + D + 4;
    expq.push_back(e);
  endtask

  task automatic ack_pulse;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  // Monitor: any press_cnt change, overrun or reject is a DUT event matched against the queue.
  initial begin
    logic [7:0] last_cnt;
    exp_t e;
    int kind;
    last_cnt = 8'h00;
    forever begin
      @(negedge clk);
      if (RESET) begin
        last_cnt = press_cnt;
      end else if ((press_cnt != last_cnt) || overrun || reject) begin
        kind = (press_cnt != last_cnt) ? K_LOAD : (overrun ? K_OVR : K_REJ);
        last_cnt = press_cnt;
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
          e = expq.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("event_cycle", 32'(cyc), 32'(e.at));
          if (e.kind == K_LOAD) begin
            check("load_valid", 32'(key_valid), 32'd1);
            check("load_code", 32'(key_code), 32'(e.code));
            check("load_index", 32'(key_index), 32'(e.idx));
            check("load_cnt", 32'(press_cnt), 32'(e.cnt));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    RESET = 1'b1; keypad = 8'h04; ack = 1'b0;

    // Reset with a key already down: everything cleared, then key re-detected.
    tick(1);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_index", 32'(key_index), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    check("rst_cnt", 32'(press_cnt), 32'd0);
    tick(1);
    RESET = 1'b0;
    push_load(8'h04, 3'd2);
    tick(10);
    check("s1_held", 32'(held), 32'h04);
    ack_pulse();
    check("s1_ack_valid", 32'(key_valid), 32'd0);
    check("s1_ack_code", 32'(key_code), 32'd0);
    check("s1_ack_index", 32'(key_index), 32'd0);
    keypad = 8'h00;
    tick(10);

    // Bounce: short high stretches never reach held; final steady level gives one press.
    for (int i = 0; i < 5; i++) begin
      keypad = 8'h10; tick(2);
      keypad = 8'h00; tick(2);
    end
    keypad = 8'h10;
    push_load(8'h10, 3'd4);
    tick(12);
    ack_pulse();
    keypad = 8'h00;
    tick(10);

    // Chord: second key while first held is rejected, entry untouched.
    keypad = 8'h01;
    push_load(8'h01, 3'd0);
    tick(10);
    keypad = 8'h81;
    push_pulse(K_REJ);
    tick(12);
    check("chord_code", 32'(key_code), 32'h01);
    check("chord_valid", 32'(key_valid), 32'd1);
    ack_pulse();
    keypad = 8'h00;
    tick(10);

    // Overrun: new press while full and un-acked is dropped.
    keypad = 8'h02;
    push_load(8'h02, 3'd1);
    tick(10);
    keypad = 8'h00;
    tick(10);
    keypad = 8'h20;
    push_pulse(K_OVR);
    tick(12);
    check("ovr_code", 32'(key_code), 32'h02);
    check("ovr_cnt", 32'(press_cnt), 32'd4);
    ack_pulse();
    check("ovr_ack_valid", 32'(key_valid), 32'd0);
    check("ovr_ack_code", 32'(key_code), 32'h00);
    keypad = 8'h00;
    tick(10);

    // Ack on the exact edge a new press loads: entry replaced, stays valid.
    keypad = 8'h08;
    push_load(8'h08, 3'd3);
    tick(10);
    keypad = 8'h00;
    tick(10);
    keypad = 8'h40;
    push_load(8'h40, 3'd6);
    tick(D + 3);
    ack_pulse();
    check("simul_valid", 32'(key_valid), 32'd1);
    check("simul_code", 32'(key_code), 32'h40);
    check("simul_index", 32'(key_index), 32'd6);
    check("simul_overrun", 32'(overrun), 32'd0);
    tick(4);
    ack_pulse();
    keypad = 8'h00;
    tick(10);

    // Counter wrap: 256 press/ack cycles from reset bring press_cnt back to 0.
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    model_cnt = 0;
    check("wrap_start_cnt", 32'(press_cnt), 32'd0);
    for (int i = 0; i < 256; i++) begin
      v = 8'h01 << (i % 8);
      keypad = v;
      push_load(v, 3'(i % 8));
      tick(D + 5);
      ack_pulse();
      keypad = 8'h00;
      tick(D + 4);
    end
    check("wrap_end_cnt", 32'(press_cnt), 32'd0);
    check("wrap_end_valid", 32'(key_valid), 32'd0);

    tick(5);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_conditioner.md
# keypad_conditioner

Input-conditioning stage directly upstream of the mole game core. It synchronizes and debounces the 8 raw mole buttons and detects press edges. Each accepted single-key press is presented to the game logic as a one-hot code held under a valid/ack handshake, so a hit is counted exactly once per physical press. Multi-key presses, overruns and releases are filtered here, so the game core never samples raw switch levels.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive stable synchronized samples required before a level change is accepted; legal range ≥ 1.
- CNT_W, default 16: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock, all state on rising edge.
- RESET  input  1  synchronous active-high reset.
- keypad  input  8  raw asynchronous button levels, 1 = pressed.
- ack  input  1  consumer strobe; consumes the presented press.
- key_valid  output  1  a press is presented.
- key_code  output  8  one-hot code of presented key; forced 8'h00 whenever key_valid = 0.
- key_index  output  3  binary index of presented key; 0 when key_valid = 0.
- held  output  8  debounced level vector.
- overrun  output  1  one-cycle pulse: accepted press dropped because the previous one was not consumed.
- reject  output  1  one-cycle pulse: press edge occurred while more than one key was stably held.
- press_cnt  output  8  count of accepted presses, wraps 255 → 0.

## Operation
- Synchronizer:
  - s1 <= keypad, s2 <= s1, prev <= s2, every cycle.
- Debounce (one shared counter cnt, vector-wide):
  - If s2 != prev or s2 == held: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: held <= s2, cnt <= 0.
  - Else: cnt <= cnt + 1.
- Edge detect: held_d <= held; rise = held & ~held_d. Releases (falling bits) generate no event.
- Output buffer: 1-entry, states EMPTY (key_valid = 0) and FULL (key_valid = 1). Evaluated each cycle with rise != 0 as the event:
  - Event, held one-hot, state EMPTY: load key_code = held and key_index; go to FULL; press_cnt + 1.
  - Event, held one-hot, state FULL, ack = 1: replace entry; stay FULL; press_cnt + 1.
  - Event, held one-hot, state FULL, ack = 0: keep the old entry; overrun = 1 for one cycle; press_cnt unchanged.
  - Event with popcount(held) ≥ 2: reject = 1 for one cycle; no load; press_cnt unchanged. This case takes priority over the three above.
  - No event, FULL, ack = 1: go to EMPTY.
  - ack while EMPTY: ignored.
- Key held through reset: after RESET deasserts, held = 0, so the key is re-detected as a new press.

## Timing
- Reset (RESET high at an edge): s1, s2, prev, cnt, held, held_d, key_code, key_index, key_valid, overrun, reject and press_cnt are all 0. Any debounce in progress or pending entry is discarded.
- Latency: a raw change first sampled at edge 0 and held stable gives:
  - held updated at edge DEBOUNCE_CYCLES+2.
  - key_valid/key_code visible after edge DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES+1 sampled cycles never changes held.
- Handshake:
  - ack sampled at edge E with key_valid = 1 → key_valid = 0 after E, unless a new press loads at E.
  - key_valid may stay high indefinitely; the entry is never lost to time.
- overrun and reject are single-cycle pulses, asserted in the cycle after the event edge.
- press_cnt increments by exactly 1 per load; 255 + 1 = 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset behavior: RESET for 2 cycles with keypad = 8'h04 → all outputs 0 during reset. After release, key_valid = 1, key_code = 8'h04, key_index = 2 at edge 7 after release; press_cnt = 1.
- Bounce filtering: keypad = 8'h10 toggles every 2 cycles for 20 cycles, then stays high → exactly one key_valid rise, 7 edges after the final toggle; key_code = 8'h10. No overrun or reject.
- Multi-key press: keypad = 8'h01, then 8'h81 after 10 cycles → first press accepted. Second edge gives reject = 1 for one cycle and key_code stays 8'h01.
- Overrun: press 8'h02 and release, then press 8'h20 with no ack → overrun pulse; key_code stays 8'h02. Then ack → key_valid = 0 and key_code = 8'h00 next cycle.
- Simultaneous ack and new press: ack asserted on the exact edge the 8'h40 press loads, while FULL with 8'h08 → key_valid stays 1, key_code = 8'h40, key_index = 6, no overrun.
- Counter wrap: 256 accepted press/ack cycles → press_cnt returns to 0.
